// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and a
// multi-cycle data memory (slave).
interface mem_access_ctrl_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              mem_err;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_done, mem_err
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_done, mem_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM stage: issues data-memory accesses from EX/MEM, stalls the front of the
// pipeline while an access is outstanding, and registers the MEM/WB outputs.
module mem_access_ctrl #(
  parameter int DATA_W   = 16,
  parameter int SEL_W    = 3,
  parameter int MAX_WAIT = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    aluResult_XM,
  input  logic [DATA_W-1:0]    readData2_XM,
  input  logic [DATA_W-1:0]    pc_plus_2_XM,
  input  logic                 memRead_XM,
  input  logic                 memWrite_XM,
  input  logic                 memToReg_XM,
  input  logic                 regWrite_XM,
  input  logic                 writeR7_XM,
  input  logic                 HALT_XM,
  input  logic [SEL_W-1:0]     writeRegSel_XM,
  mem_access_ctrl_if.master    mem,
  output logic                 stall_M,
  output logic [DATA_W-1:0]    memData_MW,
  output logic [DATA_W-1:0]    aluResult_MW,
  output logic [DATA_W-1:0]    pc_plus_2_MW,
  output logic                 memToReg_MW,
  output logic                 regWrite_MW,
  output logic                 writeR7_MW,
  output logic                 HALT_MW,
  output logic [SEL_W-1:0]     writeRegSel_MW,
  output logic                 err
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;

  logic              req;
  logic              aligned;
  logic              in_wait;
  logic              issue;
  logic              misalign;
  logic              timeout;
  logic              done_ok;
  logic              acc_fail;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_data;

  // Both strobes set is a write; a read result is only kept for a clean load.
  always_comb begin
    req      = (memRead_XM | memWrite_XM) & ~HALT_XM;
    aligned  = ~aluResult_XM[0];
    in_wait  = (state == S_WAIT);
    issue    = rst & (state == S_IDLE) & req & aligned;
    misalign = rst & (state == S_IDLE) & req & ~aligned;
    timeout  = rst & in_wait & ~mem.mem_done & (wait_cnt == MAX_CNT);
    done_ok  = mem.mem_done & (issue | (rst & in_wait));
    acc_fail = misalign | timeout | (done_ok & mem.mem_err);
    rd_ok    = done_ok & ~mem.mem_err & ~memWrite_XM;
    rd_data  = rd_ok ? mem.mem_rdata : '0;
    stall_M  = (issue & ~mem.mem_done) |
               (rst & in_wait & ~mem.mem_done & (wait_cnt != MAX_CNT));
  end

  assign mem.mem_addr  = aluResult_XM;
  assign mem.mem_wdata = readData2_XM;
  assign mem.mem_rd    = issue & ~memWrite_XM;
  assign mem.mem_wr    = issue & memWrite_XM;

  // FSM, wait counter, sticky error and MEM/WB register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      err            <= 1'b0;
      memData_MW     <= '0;
      aluResult_MW   <= '0;
      pc_plus_2_MW   <= '0;
      memToReg_MW    <= 1'b0;
      regWrite_MW    <= 1'b0;
      writeR7_MW     <= 1'b0;
      HALT_MW        <= 1'b0;
      writeRegSel_MW <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue && !mem.mem_done) begin
            state    <= S_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (mem.mem_done || timeout) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= '0;
        end
      endcase

      if (acc_fail) err <= 1'b1;

      if (stall_M) begin
        memData_MW     <= '0;
        aluResult_MW   <= '0;
        pc_plus_2_MW   <= '0;
        memToReg_MW    <= 1'b0;
        regWrite_MW    <= 1'b0;
        writeR7_MW     <= 1'b0;
        HALT_MW        <= 1'b0;
        writeRegSel_MW <= '0;
      end else begin
        memData_MW     <= rd_data;
        aluResult_MW   <= aluResult_XM;
        pc_plus_2_MW   <= pc_plus_2_XM;
        memToReg_MW    <= memToReg_XM;
        regWrite_MW    <= regWrite_XM & ~acc_fail;
        writeR7_MW     <= writeR7_XM;
        HALT_MW        <= HALT_XM;
        writeRegSel_MW <= writeRegSel_XM;
      end
    end
  end

endmodule
